// File: rtl/axi_dw_router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_dw_router_pkg
// Description : Shared types for the AXI write-data router. This package holds
//               the FSM state encoding and the route-entry record that is
//               queued in the routing FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_dw_router_pkg;

  // Width of the stored route fields. The id field is wide enough for any
  // practical port count. The len field matches AXI AWLEN.
  localparam int unsigned ID_W  = 8;
  localparam int unsigned LEN_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
  } route_entry_t;

endpackage : axi_dw_router_pkg
`default_nettype wire

// File: rtl/axi_dw_route_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axi_dw_route_fifo
// Description : Non-fall-through FIFO of route entries. A push is refused
//               whenever the FIFO is full, even if a pop happens in the same
//               cycle. The head entry is driven as zero while the FIFO is
//               empty, so downstream muxing never sees X.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_dw_route_fifo
  import axi_dw_router_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  route_entry_t             entry_i,
  output logic                     push_ready_o,
  input  logic                     pop_i,
  output route_entry_t             entry_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_FULL_LEVEL = (PTR_W+1)'(DEPTH);

  route_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   level_q;
  logic             w_push, w_pop;

  assign empty_o      = (level_q == '0);
  assign push_ready_o = (level_q != C_FULL_LEVEL);
  assign w_push       = push_i & push_ready_o;
  assign w_pop        = pop_i & ~empty_o;
  assign level_o      = level_q;
  assign entry_o      = empty_o ? '0 : mem_q[rptr_q];

  // Storage array. The array has no reset because the level counter guards validity.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wptr_q] <= entry_i;
  end

  // Pointer and level bookkeeping. Power-of-two depth wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (w_push) wptr_q <= wptr_q + 1'b1;
      if (w_pop)  rptr_q <= rptr_q + 1'b1;
      if (w_push && !w_pop)      level_q <= level_q + 1'b1;
      else if (w_pop && !w_push) level_q <= level_q - 1'b1;
    end
  end

endmodule : axi_dw_route_fifo
`default_nettype wire

// File: rtl/axi_dw_router.sv
`default_nettype none
// ============================================================================
// Module      : axi_dw_router
// Description : Routes AXI W-channel beats from N_TARG_PORT sources to one
//               sink. The order comes from a FIFO of {id,len} route entries.
//               Optional macro AXI_DW_ROUTER_LEN_CHECK_EN enables a beat
//               counter. The counter terminates bursts by AWLEN and flags
//               WLAST mismatches on len_err_o.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_dw_router
  import axi_dw_router_pkg::*;
#(
  parameter int N_TARG_PORT = 4,
  parameter int AXI_DATA_W  = 64,
  parameter int AXI_USER_W  = 6,
  parameter int FIFO_DEPTH  = 8,
  parameter int LOG_N_TARG  = $clog2(N_TARG_PORT),
  localparam int AXI_NUMBYTES = AXI_DATA_W / 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_TARG_PORT*AXI_DATA_W-1:0]   wdata_i,
  input  logic [N_TARG_PORT*AXI_NUMBYTES-1:0] wstrb_i,
  input  logic [N_TARG_PORT-1:0]              wlast_i,
  input  logic [N_TARG_PORT*AXI_USER_W-1:0]   wuser_i,
  input  logic [N_TARG_PORT-1:0]              wvalid_i,
  output logic [N_TARG_PORT-1:0]              wready_o,
  output logic [AXI_DATA_W-1:0]               wdata_o,
  output logic [AXI_NUMBYTES-1:0]             wstrb_o,
  output logic                                wlast_o,
  output logic [AXI_USER_W-1:0]               wuser_o,
  output logic                                wvalid_o,
  input  logic                                wready_i,
  input  logic                                push_i,
  input  logic [LOG_N_TARG-1:0]               push_id_i,
  input  logic [7:0]                          push_len_i,
  output logic                                push_ready_o,
  output logic                                len_err_o,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level_o
);

  route_entry_t            w_push_entry, w_head;
  logic                    w_empty, w_fire, w_last, w_pop, w_sel_last;
  logic [LOG_N_TARG-1:0]   w_sel;
  state_e                  state_q, state_d;
  logic                    w_unused;

  // Build the queued entry. The length is kept only when the counter needs it.
  always_comb begin
    w_push_entry     = '0;
    w_push_entry.id  = ID_W'(push_id_i);
`ifdef AXI_DW_ROUTER_LEN_CHECK_EN
    w_push_entry.len = push_len_i;
`endif
  end

  axi_dw_route_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push_i),
    .entry_i      (w_push_entry),
    .push_ready_o (push_ready_o),
    .pop_i        (w_pop),
    .entry_o      (w_head),
    .empty_o      (w_empty),
    .level_o      (fifo_level_o)
  );

  // Clamp the head id to a legal port so the mux never indexes out of range.
  always_comb begin
    w_sel = '0;
    if (32'(w_head.id) < N_TARG_PORT) w_sel = w_head.id[LOG_N_TARG-1:0];
  end

  // Zero-latency data mux. The handshake is enabled only while a route entry is present.
  always_comb begin
    wvalid_o   = 1'b0;
    wready_o   = '0;
    wdata_o    = wdata_i[int'(w_sel)*AXI_DATA_W +: AXI_DATA_W];
    wstrb_o    = wstrb_i[int'(w_sel)*AXI_NUMBYTES +: AXI_NUMBYTES];
    wuser_o    = wuser_i[int'(w_sel)*AXI_USER_W +: AXI_USER_W];
    w_sel_last = wlast_i[w_sel];
    if (!w_empty) begin
      wvalid_o        = wvalid_i[w_sel];
      wready_o[w_sel] = wready_i;
    end
  end

  assign w_fire = wvalid_o & wready_i;
  assign w_pop  = w_fire & w_last;

`ifdef AXI_DW_ROUTER_LEN_CHECK_EN
  logic [7:0] cnt_q, cnt_d;
  logic       len_err_q, len_err_d;

  // The beat counter defines the final beat. The source WLAST is only compared against it.
  always_comb begin
    w_last    = (cnt_q == w_head.len);
    cnt_d     = cnt_q;
    len_err_d = 1'b0;
    if (w_fire) begin
      cnt_d     = w_last ? 8'd0 : cnt_q + 8'd1;
      len_err_d = (w_sel_last != w_last);
    end
  end

  // Beat counter and registered error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end

  assign wlast_o   = w_last;
  assign len_err_o = len_err_q;
  assign w_unused  = ^w_head.id;
`else
  assign w_last    = w_sel_last;
  assign wlast_o   = w_sel_last;
  assign len_err_o = 1'b0;
  assign w_unused  = ^{w_head, push_len_i};
`endif

  // Burst-tracking next state: enter BURST on a non-final beat and leave on the final beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_fire && !w_last) state_d = BURST;
      BURST:   if (w_fire && w_last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

endmodule : axi_dw_router
`default_nettype wire

// File: tb/tb_axi_dw_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_dw_router
// Description : Directed self-checking bench for axi_dw_router (default
//               parameters). Define AXI_DW_ROUTER_LEN_CHECK_EN to exercise
//               the counter-terminated variant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_dw_router;
  import axi_dw_router_pkg::*;

  localparam int N = 4, DW = 64, NB = 8, UW = 6, DEPTH = 8, LOGN = 2, LW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*DW-1:0]   wdata_i;
  logic [N*NB-1:0]   wstrb_i;
  logic [N-1:0]      wlast_i, wvalid_i, wready_o;
  logic [N*UW-1:0]   wuser_i;
  logic [DW-1:0]     wdata_o;
  logic [NB-1:0]     wstrb_o;
  logic [UW-1:0]     wuser_o;
  logic              wlast_o, wvalid_o, wready_i;
  logic              push_i, push_ready_o, len_err_o;
  logic [LOGN-1:0]   push_id_i;
  logic [7:0]        push_len_i;
  logic [LW-1:0]     fifo_level_o;

  int total = 0;
  int bad   = 0;
  int q[$];

  axi_dw_router #(
    .N_TARG_PORT (N), .AXI_DATA_W (DW), .AXI_USER_W (UW), .FIFO_DEPTH (DEPTH), .LOG_N_TARG (LOGN)
  ) dut (
    .clk (clk), .rst (rst),
    .wdata_i (wdata_i), .wstrb_i (wstrb_i), .wlast_i (wlast_i), .wuser_i (wuser_i),
    .wvalid_i (wvalid_i), .wready_o (wready_o),
    .wdata_o (wdata_o), .wstrb_o (wstrb_o), .wlast_o (wlast_o), .wuser_o (wuser_o),
    .wvalid_o (wvalid_o), .wready_i (wready_i),
    .push_i (push_i), .push_id_i (push_id_i), .push_len_i (push_len_i),
    .push_ready_o (push_ready_o), .len_err_o (len_err_o), .fifo_level_o (fifo_level_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] dat(input int p, input int b);
    return {32'hD0D0_0000 | 32'(p), 32'(b)};
  endfunction

  task automatic drive_port(input int p, input logic v, input logic l, input int b);
    wvalid_i[p]          = v;
    wlast_i[p]           = l;
    wdata_i[p*DW +: DW]  = dat(p, b);
    wstrb_i[p*NB +: NB]  = 8'(17 * (p + 1));
    wuser_i[p*UW +: UW]  = 6'(p + b);
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < N; p++) drive_port(p, 1'b0, 1'b0, 0);
    wready_i   = 1'b0;
    push_i     = 1'b0;
    push_id_i  = '0;
    push_len_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int p = 0; p < N; p++) drive_port(p, 1'b1, 1'b1, 0);
    wready_i = 1'b1;
    @(negedge clk); #1;
    total++; if (push_ready_o !== 1'b1) begin bad++; $display("FAIL reset_push_ready: got %b want 1", push_ready_o); end
    total++; if (wvalid_o !== 1'b0) begin bad++; $display("FAIL reset_wvalid: got %b want 0", wvalid_o); end
    total++; if (wready_o !== 4'b0000) begin bad++; $display("FAIL reset_wready: got %b want 0000", wready_o); end
    total++; if (fifo_level_o !== 4'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level_o); end
    total++; if (len_err_o !== 1'b0) begin bad++; $display("FAIL reset_len_err: got %b want 0", len_err_o); end
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    push_i = 1'b1; push_id_i = 2'd2; push_len_i = 8'd0;
    drive_port(2, 1'b1, 1'b1, 0);
    wready_i = 1'b1;
    #1;
    total++; if (wvalid_o !== 1'b0) begin bad++; $display("FAIL single_no_fallthrough: got %b want 0", wvalid_o); end
    total++; if (wready_o !== 4'b0000) begin bad++; $display("FAIL single_ready_early: got %b want 0000", wready_o); end
    @(negedge clk);
    push_i = 1'b0;
    #1;
    total++; if (fifo_level_o !== 4'd1) begin bad++; $display("FAIL single_level1: got %0d want 1", fifo_level_o); end
    total++; if (wvalid_o !== 1'b1) begin bad++; $display("FAIL single_wvalid: got %b want 1", wvalid_o); end
    total++; if (wready_o !== 4'b0100) begin bad++; $display("FAIL single_wready: got %b want 0100", wready_o); end
    total++; if (wdata_o !== dat(2, 0)) begin bad++; $display("FAIL single_data: got %h want %h", wdata_o, dat(2, 0)); end
    total++; if (wstrb_o !== 8'd51) begin bad++; $display("FAIL single_strb: got %h want 33", wstrb_o); end
    total++; if (wlast_o !== 1'b1) begin bad++; $display("FAIL single_wlast: got %b want 1", wlast_o); end
    @(negedge clk);
    drive_port(2, 1'b0, 1'b0, 0);
    wready_i = 1'b0;
    #1;
    total++; if (fifo_level_o !== 4'd0) begin bad++; $display("FAIL single_level0: got %0d want 0", fifo_level_o); end
    total++; if (wvalid_o !== 1'b0) begin bad++; $display("FAIL single_wvalid_after: got %b want 0", wvalid_o); end
  endtask

  task automatic test_burst();
    logic rdy [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int   beat = 0;
    @(negedge clk);
    push_i = 1'b1; push_id_i = 2'd1; push_len_i = 8'd3;
    wready_i = 1'b0;
    drive_port(1, 1'b1, 1'b0, 0);
    drive_port(3, 1'b1, 1'b1, 0);
    @(negedge clk);
    push_id_i = 2'd3; push_len_i = 8'd0;
    @(negedge clk);
    push_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      wready_i = rdy[c];
      drive_port(1, 1'b1, beat == 3, beat);
      #1;
      total++; if (wvalid_o !== 1'b1) begin bad++; $display("FAIL burst_wvalid c%0d: got %b want 1", c, wvalid_o); end
      total++; if (wready_o !== (rdy[c] ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL burst_wready c%0d: got %b want %b", c, wready_o, rdy[c] ? 4'b0010 : 4'b0000); end
      total++; if (wdata_o !== dat(1, beat)) begin bad++; $display("FAIL burst_data c%0d: got %h want %h", c, wdata_o, dat(1, beat)); end
      total++; if (wlast_o !== (beat == 3)) begin bad++; $display("FAIL burst_wlast c%0d: got %b want %b", c, wlast_o, beat == 3); end
      if (rdy[c]) beat++;
      @(negedge clk);
    end
    wready_i = 1'b1;
    drive_port(1, 1'b0, 1'b0, 0);
    #1;
    total++; if (wvalid_o !== 1'b1) begin bad++; $display("FAIL burst_p3_wvalid: got %b want 1", wvalid_o); end
    total++; if (wready_o !== 4'b1000) begin bad++; $display("FAIL burst_p3_wready: got %b want 1000", wready_o); end
    total++; if (wdata_o !== dat(3, 0)) begin bad++; $display("FAIL burst_p3_data: got %h want %h", wdata_o, dat(3, 0)); end
    @(negedge clk);
    drive_port(3, 1'b0, 1'b0, 0);
    wready_i = 1'b0;
    #1;
    total++; if (fifo_level_o !== 4'd0) begin bad++; $display("FAIL burst_level_end: got %0d want 0", fifo_level_o); end
  endtask

  task automatic test_full();
    q.delete();
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      push_i = 1'b1; push_id_i = LOGN'(k % 4); push_len_i = 8'd0;
      q.push_back(k % 4);
    end
    @(negedge clk);
    push_id_i = 2'd1;
    #1;
    total++; if (fifo_level_o !== 4'd8) begin bad++; $display("FAIL full_level: got %0d want 8", fifo_level_o); end
    total++; if (push_ready_o !== 1'b0) begin bad++; $display("FAIL full_push_ready: got %b want 0", push_ready_o); end
    @(negedge clk);
    push_i = 1'b0;
    #1;
    total++; if (fifo_level_o !== 4'd8) begin bad++; $display("FAIL full_drop_level: got %0d want 8", fifo_level_o); end
    // Pop while full, with a push in the same cycle: the push is refused.
    @(negedge clk);
    for (int p = 0; p < N; p++) drive_port(p, 1'b1, 1'b1, 0);
    wready_i = 1'b1; push_i = 1'b1; push_id_i = 2'd2;
    #1;
    total++; if (wready_o !== 4'b0001) begin bad++; $display("FAIL full_pop_sel: got %b want 0001", wready_o); end
    total++; if (push_ready_o !== 1'b0) begin bad++; $display("FAIL full_pop_push_ready: got %b want 0", push_ready_o); end
    void'(q.pop_front());
    @(negedge clk);
    push_id_i = 2'd3;
    #1;
    total++; if (fifo_level_o !== 4'd7) begin bad++; $display("FAIL full_after_pop_level: got %0d want 7", fifo_level_o); end
    total++; if (wready_o !== 4'b0010) begin bad++; $display("FAIL full_pop2_sel: got %b want 0010", wready_o); end
    void'(q.pop_front());
    q.push_back(3);
    @(negedge clk);
    wready_i = 1'b0; push_id_i = 2'd2;
    #1;
    total++; if (fifo_level_o !== 4'd7) begin bad++; $display("FAIL full_pushpop_level: got %0d want 7", fifo_level_o); end
    q.push_back(2);
    @(negedge clk);
    push_i = 1'b0;
    #1;
    total++; if (fifo_level_o !== 4'd8) begin bad++; $display("FAIL full_refill_level: got %0d want 8", fifo_level_o); end
    @(negedge clk);
    wready_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      total++; if (wready_o !== 4'(1 << q[0])) begin bad++; $display("FAIL full_drain_order %0d: got %b want %b", i, wready_o, 4'(1 << q[0])); end
      void'(q.pop_front());
      @(negedge clk);
    end
    idle_inputs();
    #1;
    total++; if (fifo_level_o !== 4'd0) begin bad++; $display("FAIL full_drained: got %0d want 0", fifo_level_o); end
  endtask

  task automatic test_len();
    @(negedge clk);
    push_i = 1'b1; push_id_i = 2'd0; push_len_i = 8'd3;
    @(negedge clk);
    push_i = 1'b0; wready_i = 1'b1;
    drive_port(0, 1'b1, 1'b0, 0);
    #1;
    total++; if (wvalid_o !== 1'b1) begin bad++; $display("FAIL len_b1_valid: got %b want 1", wvalid_o); end
    total++; if (wlast_o !== 1'b0) begin bad++; $display("FAIL len_b1_wlast: got %b want 0", wlast_o); end
    @(negedge clk);
    drive_port(0, 1'b1, 1'b1, 1);
    #1;
`ifdef AXI_DW_ROUTER_LEN_CHECK_EN
    total++; if (wlast_o !== 1'b0) begin bad++; $display("FAIL len_b2_wlast: got %b want 0", wlast_o); end
    @(negedge clk);
    drive_port(0, 1'b1, 1'b0, 2);
    #1;
    total++; if (len_err_o !== 1'b1) begin bad++; $display("FAIL len_err_pulse: got %b want 1", len_err_o); end
    total++; if (wlast_o !== 1'b0) begin bad++; $display("FAIL len_b3_wlast: got %b want 0", wlast_o); end
    @(negedge clk);
    drive_port(0, 1'b1, 1'b0, 3);
    #1;
    total++; if (len_err_o !== 1'b0) begin bad++; $display("FAIL len_err_clear: got %b want 0", len_err_o); end
    total++; if (wlast_o !== 1'b1) begin bad++; $display("FAIL len_b4_wlast: got %b want 1", wlast_o); end
    @(negedge clk);
    drive_port(0, 1'b0, 1'b0, 0);
    wready_i = 1'b0;
    #1;
    total++; if (len_err_o !== 1'b1) begin bad++; $display("FAIL len_err_final: got %b want 1", len_err_o); end
`else
    total++; if (wlast_o !== 1'b1) begin bad++; $display("FAIL len_b2_wlast: got %b want 1", wlast_o); end
    @(negedge clk);
    drive_port(0, 1'b0, 1'b0, 0);
    wready_i = 1'b0;
    #1;
    total++; if (len_err_o !== 1'b0) begin bad++; $display("FAIL len_err_tied: got %b want 0", len_err_o); end
    total++; if (wvalid_o !== 1'b0) begin bad++; $display("FAIL len_end_valid: got %b want 0", wvalid_o); end
`endif
    total++; if (fifo_level_o !== 4'd0) begin bad++; $display("FAIL len_end_level: got %0d want 0", fifo_level_o); end
    total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL len_end_state: got %b want IDLE", dut.state_q); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    push_i = 1'b1; push_id_i = 2'd1; push_len_i = 8'd7;
    drive_port(1, 1'b1, 1'b0, 0);
    drive_port(2, 1'b1, 1'b1, 0);
    @(negedge clk);
    push_id_i = 2'd2; push_len_i = 8'd0;
    wready_i = 1'b1;
    @(negedge clk);
    push_i = 1'b0;
    drive_port(1, 1'b1, 1'b0, 1);
    rst = 1'b1;
    #1;
    total++; if (wvalid_o !== 1'b0) begin bad++; $display("FAIL rstmid_wvalid: got %b want 0", wvalid_o); end
    total++; if (wready_o !== 4'b0000) begin bad++; $display("FAIL rstmid_wready: got %b want 0000", wready_o); end
    total++; if (fifo_level_o !== 4'd0) begin bad++; $display("FAIL rstmid_level: got %0d want 0", fifo_level_o); end
    total++; if (push_ready_o !== 1'b1) begin bad++; $display("FAIL rstmid_push_ready: got %b want 1", push_ready_o); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (wvalid_o !== 1'b0) begin bad++; $display("FAIL rstmid_after_wvalid: got %b want 0", wvalid_o); end
    total++; if (wready_o !== 4'b0000) begin bad++; $display("FAIL rstmid_after_wready: got %b want 0000", wready_o); end
    @(negedge clk);
    #1;
    total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL rstmid_state: got %b want IDLE", dut.state_q); end
    total++; if (fifo_level_o !== 4'd0) begin bad++; $display("FAIL rstmid_level_after: got %0d want 0", fifo_level_o); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    int n_pushed = 0, n_popped = 0, cycles = 0, pre;
    logic acc;
    q.delete();
    for (int p = 0; p < N; p++) drive_port(p, 1'b1, 1'b1, 0);
    while (n_popped < 20 && cycles < 400) begin
      @(negedge clk);
      push_i    = (n_pushed < 20);
      push_id_i = LOGN'((n_pushed * 3 + 1) % 4);
      wready_i  = 1'($urandom_range(0, 1));
      #1;
      pre = q.size();
      total++; if (fifo_level_o !== 4'(pre)) begin bad++; $display("FAIL wrap_level c%0d: got %0d want %0d", cycles, fifo_level_o, pre); end
      total++; if (wvalid_o !== (pre != 0)) begin bad++; $display("FAIL wrap_wvalid c%0d: got %b want %b", cycles, wvalid_o, pre != 0); end
      if (pre != 0) begin
        total++; if (wready_o !== (wready_i ? 4'(1 << q[0]) : 4'b0000)) begin bad++; $display("FAIL wrap_wready c%0d: got %b want %b", cycles, wready_o, wready_i ? 4'(1 << q[0]) : 4'b0000); end
        total++; if (wdata_o !== dat(q[0], 0)) begin bad++; $display("FAIL wrap_data c%0d: got %h want %h", cycles, wdata_o, dat(q[0], 0)); end
        if (wready_i) begin
          void'(q.pop_front());
          n_popped++;
        end
      end
      acc = push_i && (pre != DEPTH);
      if (acc) begin
        q.push_back((n_pushed * 3 + 1) % 4);
        n_pushed++;
      end
      cycles++;
    end
    total++; if (n_popped != 20) begin bad++; $display("FAIL wrap_timeout: got %0d pops want 20", n_popped); end
    @(negedge clk);
    idle_inputs();
    #1;
    total++; if (fifo_level_o !== 4'd0) begin bad++; $display("FAIL wrap_end_level: got %0d want 0", fifo_level_o); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_burst();
    test_full();
    test_len();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_axi_dw_router
`default_nettype wire
